pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
- Breathing/fade sequencer that drives the compare value of the project's PWM generator (COUNTER_WIDTH-bit counter, cmp_value input, period_start output).
- Ramps the duty cycle up to a maximum, holds, ramps down to a minimum, holds, and repeats.
- All compare-value changes happen on PWM period boundaries, so no glitched PWM periods occur.
- Sits in the top level between the configuration inputs and the PWM instance.

Parameters:
- COUNTER_WIDTH, 10, width of the compare value; must match the PWM instance.
- STEP_WIDTH, 4, width of the per-period ramp increment.
- HOLD_WIDTH, 8, width of the hold-period counter and its configuration.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- enable_i  input  1  run the fade sequence
- period_start_i  input  1  single-cycle pulse from the PWM at the start of each period
- step_i  input  STEP_WIDTH  increment/decrement per period; 0 is treated as 1
- min_value_i  input  COUNTER_WIDTH  lower ramp limit
- max_value_i  input  COUNTER_WIDTH  upper ramp limit
- hold_periods_i  input  HOLD_WIDTH  extra periods to dwell at each limit
- cmp_value_o  output  COUNTER_WIDTH  compare value to the PWM (registered)
- state_o  output  3  current state encoding
- cycle_done_o  output  1  single-cycle pulse when one full breath completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cmp_value_o=0, state_o=IDLE, cycle_done_o=0, hold counter=0.
- State encoding: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- Timing rule: the FSM advances only in a cycle where period_start_i=1. Config inputs are sampled only in that cycle. New cmp_value_o is visible the following cycle (1-cycle latency). Between pulses all state holds.
- Effective step s = (step_i==0) ? 1 : step_i, zero-extended.
- Ramp arithmetic uses COUNTER_WIDTH+1 bits, so there is no wrap-around.
- IDLE:
  - cmp=0.
  - If enable_i=1: go to RAMP_UP, cmp=min_value_i, cnt=0.
- RAMP_UP:
  - Compute sum = cmp + s.
  - If sum >= max_value_i: cmp=max_value_i, go to HOLD_HIGH, cnt=0.
  - Otherwise: cmp=sum.
- HOLD_HIGH:
  - If cnt == hold_periods_i: go to RAMP_DOWN, cnt=0; cmp unchanged.
  - Otherwise: cnt++.
- RAMP_DOWN:
  - If cmp <= min_value_i + s: cmp=min_value_i, go to HOLD_LOW, cnt=0.
  - Otherwise: cmp = cmp - s.
- HOLD_LOW:
  - Same dwell rule as HOLD_HIGH.
  - On exit: go to RAMP_UP, cmp unchanged, and pulse cycle_done_o for exactly one clk cycle (the cycle after the period_start).
- Disable: enable_i=0 at a period_start in any non-IDLE state takes priority over all transitions. It sets IDLE, cmp=0, cnt=0, and cycle_done_o is not pulsed.
- Degenerate limits (min_value_i >= max_value_i):
  - RAMP_UP saturates immediately to max.
  - RAMP_DOWN saturates immediately to min.
  - No error flag is raised.
- Config changed mid-ramp: new limits take effect at the next period_start. If cmp already exceeds a new max in RAMP_UP, the saturate rule applies (cmp=max).
- Reset asserted mid-operation: all registers return to reset values on the next clk edge, regardless of period_start_i.
- cmp_value_o never changes in a cycle without a preceding period_start_i pulse (except on reset).

Optional Feature:
- Macro: PWM_FADE_ONESHOT_EN.
- With the macro defined:
  - Adds input port oneshot_i (1 bit), sampled at period_start.
  - If oneshot_i=1 on HOLD_LOW exit: go to IDLE (cmp=0) instead of RAMP_UP. cycle_done_o still pulses.
  - Re-arm requires enable_i=1 at a later period_start while in IDLE.
- Without the macro: port absent; the sequence loops indefinitely.

Test Plan:
- Basic ramp:
  - Stimulus: rst, then enable=1, min=0, max=0x1FF, step=0x4, hold=0, pulse period_start every 16 cycles.
  - Response: cmp sequence 0x000, 0x040, …, 0x1C0, then 0x1FF with state=HOLD_HIGH at the 9th pulse.
  - step_i=0x4 is a typo: STEP_WIDTH=4 cannot hold 0x40. Use STEP_WIDTH=8, step=0x40.
- Hold and ramp down:
  - Stimulus: hold=2, max=0x100, min=0x010, step=0x80.
  - Response: HOLD_HIGH spans 3 pulses; then cmp 0x100 → 0x080 → 0x010 (HOLD_LOW); cycle_done pulses once, 1 cycle wide, on HOLD_LOW exit.
- Step zero and degenerate limits:
  - Stimulus: step=0, min=0x005, max=0x008.
  - Response: cmp 5, 6, 7, 8 at successive pulses.
  - Stimulus: min=0x20, max=0x10.
  - Response: cmp=0x10 after the first RAMP_UP pulse.
- Disable and reset mid-ramp:
  - Stimulus: enable=0 during RAMP_DOWN at cmp=0x0C0.
  - Response: next pulse gives IDLE, cmp=0, no cycle_done.
  - Stimulus: rst asserted between pulses.
  - Response: cmp=0, state=IDLE on the next clk edge.
- No-pulse stability:
  - Stimulus: hold period_start_i=0 for 1000 cycles in RAMP_UP while toggling config inputs.
  - Response: cmp_value_o and state_o constant.
- Oneshot (PWM_FADE_ONESHOT_EN):
  - Stimulus: oneshot_i=1.
  - Response: after HOLD_LOW exit, state=IDLE, cmp=0, cycle_done pulsed once; no further ramping until the enable re-arm condition.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Breathing/fade sequencer that steps a PWM compare value on period boundaries.
// Optional macro PWM_FADE_ONESHOT_EN adds oneshot_i to stop after one full breath.
module pwm_fade_ctrl #(
  parameter int COUNTER_WIDTH = 10,
  parameter int STEP_WIDTH    = 4,
  parameter int HOLD_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     period_start_i,
  input  logic [STEP_WIDTH-1:0]    step_i,
  input  logic [COUNTER_WIDTH-1:0] min_value_i,
  input  logic [COUNTER_WIDTH-1:0] max_value_i,
  input  logic [HOLD_WIDTH-1:0]    hold_periods_i,
`ifdef PWM_FADE_ONESHOT_EN
  input  logic                     oneshot_i,
`endif
  output logic [COUNTER_WIDTH-1:0] cmp_value_o,
  output logic [2:0]               state_o,
  output logic                     cycle_done_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  // One extra bit so cmp + step and min + step can never wrap.
  localparam int                  SW       = COUNTER_WIDTH + 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] cmp, cmp_next;
  logic [HOLD_WIDTH-1:0]    cnt, cnt_next;
  logic                     done, done_next;

  logic [SW-1:0] step_ext;
  logic [SW-1:0] sum_up;
  logic [SW-1:0] floor_dn;
  logic          hold_done;

  always_comb begin
    step_ext  = (step_i == '0) ? SW'(1) : SW'(step_i);
    sum_up    = {1'b0, cmp} + step_ext;
    floor_dn  = {1'b0, min_value_i} + step_ext;
    hold_done = (cnt == hold_periods_i);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    cmp_next   = cmp;
    cnt_next   = cnt;
    done_next  = 1'b0;

    if (period_start_i) begin
      if (!enable_i) begin
        state_next = IDLE;
        cmp_next   = '0;
        cnt_next   = '0;
      end else begin
        unique case (state)
          IDLE: begin
            state_next = RAMP_UP;
            cmp_next   = min_value_i;
            cnt_next   = '0;
          end
          RAMP_UP: begin
            if (sum_up >= {1'b0, max_value_i}) begin
              state_next = HOLD_HIGH;
              cmp_next   = max_value_i;
              cnt_next   = '0;
            end else begin
              cmp_next = sum_up[COUNTER_WIDTH-1:0];
            end
          end
          HOLD_HIGH: begin
            if (hold_done) begin
              state_next = RAMP_DOWN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + HOLD_ONE;
            end
          end
          RAMP_DOWN: begin
            // cmp > min + s here, so the subtraction cannot underflow.
            if ({1'b0, cmp} <= floor_dn) begin
              state_next = HOLD_LOW;
              cmp_next   = min_value_i;
              cnt_next   = '0;
            end else begin
              cmp_next = cmp - step_ext[COUNTER_WIDTH-1:0];
            end
          end
          HOLD_LOW: begin
            if (hold_done) begin
              done_next  = 1'b1;
              cnt_next   = '0;
              state_next = RAMP_UP;
`ifdef PWM_FADE_ONESHOT_EN
              if (oneshot_i) begin
                state_next = IDLE;
                cmp_next   = '0;
              end
`endif
            end else begin
              cnt_next = cnt + HOLD_ONE;
            end
          end
          default: begin
            state_next = IDLE;
            cmp_next   = '0;
            cnt_next   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmp   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cmp   <= cmp_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  assign cmp_value_o  = cmp;
  assign state_o      = state;
  assign cycle_done_o = done;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl (built with STEP_WIDTH=8).
// Honours PWM_FADE_ONESHOT_EN to exercise the oneshot port when it is present.
module tb_pwm_fade_ctrl;

  localparam int CW = 10;
  localparam int SW = 8;
  localparam int HW = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_HH = 3'd2, S_DN = 3'd3, S_HL = 3'd4;

  localparam logic [CW-1:0] HRD_CMP [11] = '{10'h010, 10'h090, 10'h100, 10'h100, 10'h100,
                                              10'h100, 10'h080, 10'h010, 10'h010, 10'h010, 10'h010};
  localparam logic [2:0]    HRD_ST  [11] = '{S_UP, S_UP, S_HH, S_HH, S_HH,
                                              S_DN, S_DN, S_HL, S_HL, S_HL, S_UP};

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          period_start;
  logic [SW-1:0] step;
  logic [CW-1:0] min_value;
  logic [CW-1:0] max_value;
  logic [HW-1:0] hold_periods;
  logic          oneshot;
  logic [CW-1:0] cmp_value;
  logic [2:0]    state;
  logic          cycle_done;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_fade_ctrl #(.COUNTER_WIDTH(CW), .STEP_WIDTH(SW), .HOLD_WIDTH(HW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .period_start_i (period_start),
    .step_i         (step),
    .min_value_i    (min_value),
    .max_value_i    (max_value),
    .hold_periods_i (hold_periods),
`ifdef PWM_FADE_ONESHOT_EN
    .oneshot_i      (oneshot),
`endif
    .cmp_value_o    (cmp_value),
    .state_o        (state),
    .cycle_done_o   (cycle_done)
  );

  always #5 clk = ~clk;

  // Pulse period_start for one cycle; returns at the first negedge after the update.
  task automatic pulse();
    repeat (3) @(negedge clk);
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [SW-1:0] s, input logic [CW-1:0] lo,
                         input logic [CW-1:0] hi, input logic [HW-1:0] h);
    step = s; min_value = lo; max_value = hi; hold_periods = h;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; period_start = 1'b0; oneshot = 1'b0;
    set_cfg(8'h00, 10'h000, 10'h000, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_IDLE || cycle_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: cmp=%h state=%0d done=%b, expected cmp=000 state=0 done=0",
               cmp_value, state, cycle_done);
    end
    // Idle with enable low stays idle across a pulse.
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_IDLE) begin
      n_bad++;
      $display("FAIL idle_disabled: cmp=%h state=%0d, expected cmp=000 state=0", cmp_value, state);
    end
  endtask

  task automatic test_basic_ramp();
    logic [CW-1:0] exp_cmp;
    logic [2:0]    exp_st;
    do_reset();
    set_cfg(8'h40, 10'h000, 10'h1FF, 8'h00);
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      pulse();
      exp_cmp = (k < 9) ? CW'((k - 1) * 'h40) : 10'h1FF;
      exp_st  = (k < 9) ? S_UP : S_HH;
      n_cmp++;
      if (cmp_value !== exp_cmp || state !== exp_st) begin
        n_bad++;
        $display("FAIL basic_ramp pulse %0d: cmp=%h state=%0d, expected cmp=%h state=%0d",
                 k, cmp_value, state, exp_cmp, exp_st);
      end
    end
  endtask

  task automatic test_hold_ramp_down();
    logic exp_done;
    do_reset();
    set_cfg(8'h80, 10'h010, 10'h100, 8'h02);
    enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      pulse();
      exp_done = (k == 10);
      n_cmp++;
      if (cmp_value !== HRD_CMP[k] || state !== HRD_ST[k] || cycle_done !== exp_done) begin
        n_bad++;
        $display("FAIL hold_ramp_down pulse %0d: cmp=%h state=%0d done=%b, expected cmp=%h state=%0d done=%b",
                 k + 1, cmp_value, state, cycle_done, HRD_CMP[k], HRD_ST[k], exp_done);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cycle_done !== 1'b0) begin
      n_bad++;
      $display("FAIL cycle_done_width: done=%b, expected 0 one cycle later", cycle_done);
    end
  endtask

  task automatic test_step_zero();
    logic [CW-1:0] exp_cmp;
    do_reset();
    set_cfg(8'h00, 10'h005, 10'h008, 8'h00);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse();
      exp_cmp = CW'(5 + k);
      n_cmp++;
      if (cmp_value !== exp_cmp || state !== ((k == 3) ? S_HH : S_UP)) begin
        n_bad++;
        $display("FAIL step_zero pulse %0d: cmp=%h state=%0d, expected cmp=%h", k + 1, cmp_value, state, exp_cmp);
      end
    end
  endtask

  task automatic test_degenerate();
    do_reset();
    set_cfg(8'h01, 10'h020, 10'h010, 8'h00);
    enable = 1'b1;
    pulse();
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h010 || state !== S_HH) begin
      n_bad++;
      $display("FAIL degenerate_up: cmp=%h state=%0d, expected cmp=010 state=2", cmp_value, state);
    end
    pulse();
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h020 || state !== S_HL) begin
      n_bad++;
      $display("FAIL degenerate_down: cmp=%h state=%0d, expected cmp=020 state=4", cmp_value, state);
    end
  endtask

  task automatic test_disable();
    do_reset();
    set_cfg(8'h40, 10'h000, 10'h100, 8'h00);
    enable = 1'b1;
    repeat (7) pulse();
    n_cmp++;
    if (cmp_value !== 10'h0C0 || state !== S_DN) begin
      n_bad++;
      $display("FAIL disable_setup: cmp=%h state=%0d, expected cmp=0c0 state=3", cmp_value, state);
    end
    enable = 1'b0;
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_IDLE || cycle_done !== 1'b0) begin
      n_bad++;
      $display("FAIL disable: cmp=%h state=%0d done=%b, expected cmp=000 state=0 done=0",
               cmp_value, state, cycle_done);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cfg(8'h40, 10'h000, 10'h1FF, 8'h00);
    enable = 1'b1;
    repeat (3) pulse();
    n_cmp++;
    if (cmp_value !== 10'h080 || state !== S_UP) begin
      n_bad++;
      $display("FAIL reset_mid_setup: cmp=%h state=%0d, expected cmp=080 state=1", cmp_value, state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid: cmp=%h state=%0d, expected cmp=000 state=0", cmp_value, state);
    end
  endtask

  task automatic test_no_pulse();
    int bad_cycles;
    do_reset();
    set_cfg(8'h40, 10'h000, 10'h1FF, 8'h00);
    enable = 1'b1;
    repeat (3) pulse();
    bad_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      enable       = 1'($urandom);
      step         = SW'($urandom);
      min_value    = CW'($urandom);
      max_value    = CW'($urandom);
      hold_periods = HW'($urandom);
      oneshot      = 1'($urandom);
      @(negedge clk);
      if (cmp_value !== 10'h080 || state !== S_UP || cycle_done !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL no_pulse_stable: %0d cycles changed, expected 0 (last cmp=%h state=%0d)",
               bad_cycles, cmp_value, state);
    end
    set_cfg(8'h40, 10'h000, 10'h1FF, 8'h00);
    enable = 1'b1; oneshot = 1'b0;
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h0C0 || state !== S_UP) begin
      n_bad++;
      $display("FAIL no_pulse_resume: cmp=%h state=%0d, expected cmp=0c0 state=1", cmp_value, state);
    end
  endtask

  // Full breath ending at HOLD_LOW exit: loops back, or stops when oneshot is set.
  task automatic test_hold_low_exit();
    logic [2:0] exp_st;
    do_reset();
    set_cfg(8'h40, 10'h000, 10'h080, 8'h00);
    enable  = 1'b1;
    oneshot = 1'b1;
    repeat (6) pulse();
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_HL) begin
      n_bad++;
      $display("FAIL breath_setup: cmp=%h state=%0d, expected cmp=000 state=4", cmp_value, state);
    end
    pulse();
`ifdef PWM_FADE_ONESHOT_EN
    exp_st = S_IDLE;
`else
    exp_st = S_UP;
`endif
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== exp_st || cycle_done !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_low_exit: cmp=%h state=%0d done=%b, expected cmp=000 state=%0d done=1",
               cmp_value, state, cycle_done, exp_st);
    end
`ifdef PWM_FADE_ONESHOT_EN
    enable = 1'b0;
    repeat (2) pulse();
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_IDLE || cycle_done !== 1'b0) begin
      n_bad++;
      $display("FAIL oneshot_parked: cmp=%h state=%0d done=%b, expected cmp=000 state=0 done=0",
               cmp_value, state, cycle_done);
    end
    enable = 1'b1;
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h000 || state !== S_UP) begin
      n_bad++;
      $display("FAIL oneshot_rearm: cmp=%h state=%0d, expected cmp=000 state=1", cmp_value, state);
    end
`else
    pulse();
    n_cmp++;
    if (cmp_value !== 10'h040 || state !== S_UP || cycle_done !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_continue: cmp=%h state=%0d done=%b, expected cmp=040 state=1 done=0",
               cmp_value, state, cycle_done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_hold_ramp_down();
    test_step_zero();
    test_degenerate();
    test_disable();
    test_reset_mid();
    test_no_pulse();
    test_hold_low_exit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
